// File: rtl/branch_resolve_ctrl.sv
// Branch resolution sequencer around the 2-bit predictor: keeps an in-order queue of
// in-flight predictions, issues predictor updates, and raises a flush on mispredicts.
module branch_resolve_ctrl #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       pred_valid_i,
  input  logic                       pred_taken_i,
  input  logic [PC_W-1:0]            pred_alt_pc_i,
  output logic                       pred_ready_o,
  input  logic                       res_valid_i,
  input  logic                       res_taken_i,
  output logic                       flush_o,
  output logic [PC_W-1:0]            redirect_pc_o,
  output logic                       upd_valid_o,
  output logic                       upd_taken_o,
  output logic                       upd_pred_o,
  output logic [$clog2(DEPTH):0]     inflight_o,
  output logic [CNT_W-1:0]           branch_cnt_o,
  output logic [CNT_W-1:0]           mispred_cnt_o,
  output logic                       err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {RUN, FLUSH} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   head_q, tail_q;
  logic [CW-1:0]   count_q;
  logic            pred_mem [DEPTH];
  logic [PC_W-1:0] alt_mem  [DEPTH];

  logic            in_run, not_full, do_resolve, empty_resolve, mispredict, do_push;
  logic            head_pred;
  logic [PC_W-1:0] head_alt;

  // A correct resolve frees the head slot in the same cycle, so a push is taken even when full.
  always_comb begin
    head_pred     = pred_mem[head_q];
    head_alt      = alt_mem[head_q];
    in_run        = (state_q == RUN);
    not_full      = (count_q < CW'(DEPTH));
    pred_ready_o  = in_run & not_full;
    do_resolve    = in_run & res_valid_i & (count_q != '0);
    empty_resolve = in_run & res_valid_i & (count_q == '0);
    mispredict    = do_resolve & (res_taken_i != head_pred);
    do_push       = in_run & pred_valid_i & ~mispredict & (not_full | do_resolve);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (mispredict) state_d = FLUSH;
      FLUSH:   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= RUN;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (mispredict) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push)    tail_q <= tail_q + 1'b1;
      if (do_resolve) head_q <= head_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_resolve);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      pred_mem[tail_q] <= pred_taken_i;
      alt_mem[tail_q]  <= pred_alt_pc_i;
    end
  end

  // Update/flush strobes are registered, giving one cycle of latency from the resolve.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      upd_valid_o   <= 1'b0;
      upd_taken_o   <= 1'b0;
      upd_pred_o    <= 1'b0;
      flush_o       <= 1'b0;
      redirect_pc_o <= '0;
      branch_cnt_o  <= '0;
      mispred_cnt_o <= '0;
      err_o         <= 1'b0;
    end else begin
      upd_valid_o <= do_resolve;
      upd_taken_o <= do_resolve & res_taken_i;
      upd_pred_o  <= do_resolve & head_pred;
      flush_o     <= mispredict;
      if (mispredict)                         redirect_pc_o <= head_alt;
      if (do_resolve && branch_cnt_o != '1)   branch_cnt_o  <= branch_cnt_o + 1'b1;
      if (mispredict && mispred_cnt_o != '1)  mispred_cnt_o <= mispred_cnt_o + 1'b1;
      if (empty_resolve)                      err_o         <= 1'b1;
    end
  end

  assign inflight_o = count_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Self-checking bench for branch_resolve_ctrl: directed scenarios plus random traffic,
// all compared against a queue-based reference model of the resolution rules.
module tb_branch_resolve_ctrl;

  localparam int DEPTH = 4;
  localparam int PC_W  = 32;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              pred_valid_i, pred_taken_i;
  logic [PC_W-1:0]   pred_alt_pc_i;
  logic              pred_ready_o;
  logic              res_valid_i, res_taken_i;
  logic              flush_o;
  logic [PC_W-1:0]   redirect_pc_o;
  logic              upd_valid_o, upd_taken_o, upd_pred_o;
  logic [2:0]        inflight_o;
  logic [CNT_W-1:0]  branch_cnt_o, mispred_cnt_o;
  logic              err_o;

  branch_resolve_ctrl #(.DEPTH(DEPTH), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .pred_valid_i(pred_valid_i), .pred_taken_i(pred_taken_i), .pred_alt_pc_i(pred_alt_pc_i),
    .pred_ready_o(pred_ready_o),
    .res_valid_i(res_valid_i), .res_taken_i(res_taken_i),
    .flush_o(flush_o), .redirect_pc_o(redirect_pc_o),
    .upd_valid_o(upd_valid_o), .upd_taken_o(upd_taken_o), .upd_pred_o(upd_pred_o),
    .inflight_o(inflight_o), .branch_cnt_o(branch_cnt_o), .mispred_cnt_o(mispred_cnt_o),
    .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic            taken;
    logic [PC_W-1:0] alt;
  } entry_t;

  // Reference model state
  entry_t          m_q[$];
  bit              m_flush_cycle;
  int              m_branch, m_mispred;
  bit              m_err, m_upd_valid, m_upd_taken, m_upd_pred, m_flush;
  logic [PC_W-1:0] m_redirect;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_flush_cycle = 0;
    m_branch = 0; m_mispred = 0;
    m_err = 0; m_upd_valid = 0; m_upd_taken = 0; m_upd_pred = 0; m_flush = 0;
    m_redirect = '0;
  endtask

  // One clock of the specified behaviour, evaluated on pre-edge state and inputs.
  task automatic model_clock(input bit pv, input bit pt, input logic [PC_W-1:0] palt,
                             input bit rv, input bit rt);
    bit resolved, mis;
    int size_before;
    entry_t e;
    resolved = 0; mis = 0;
    m_upd_valid = 0; m_upd_taken = 0; m_upd_pred = 0; m_flush = 0;
    if (m_flush_cycle) begin
      m_flush_cycle = 0;
    end else begin
      size_before = m_q.size();
      if (rv && size_before > 0) begin
        e = m_q.pop_front();
        resolved = 1;
        m_upd_valid = 1; m_upd_taken = rt; m_upd_pred = e.taken;
        if (m_branch < CMAX) m_branch++;
        if (rt != e.taken) begin
          mis = 1;
          m_flush = 1;
          m_redirect = e.alt;
          if (m_mispred < CMAX) m_mispred++;
          m_q.delete();
          m_flush_cycle = 1;
        end
      end else if (rv) begin
        m_err = 1;
      end
      if (!mis && pv && (size_before < DEPTH || resolved))
        m_q.push_back('{taken: pt, alt: palt});
    end
  endtask

  task automatic check_outputs(input string ctx);
    check({ctx, ".flush"}, 32'(flush_o), 32'(m_flush));
    check({ctx, ".upd_valid"}, 32'(upd_valid_o), 32'(m_upd_valid));
    if (m_upd_valid) begin
      check({ctx, ".upd_taken"}, 32'(upd_taken_o), 32'(m_upd_taken));
      check({ctx, ".upd_pred"}, 32'(upd_pred_o), 32'(m_upd_pred));
    end
    check({ctx, ".redirect"}, redirect_pc_o, m_redirect);
    check({ctx, ".inflight"}, 32'(inflight_o), 32'(m_q.size()));
    check({ctx, ".branch_cnt"}, 32'(branch_cnt_o), 32'(m_branch));
    check({ctx, ".mispred_cnt"}, 32'(mispred_cnt_o), 32'(m_mispred));
    check({ctx, ".err"}, 32'(err_o), 32'(m_err));
  endtask

  task automatic step(input string ctx, input bit pv, input bit pt, input logic [PC_W-1:0] palt,
                      input bit rv, input bit rt);
    bit exp_ready;
    @(negedge clk_i);
    pred_valid_i = pv; pred_taken_i = pt; pred_alt_pc_i = palt;
    res_valid_i = rv; res_taken_i = rt;
    #1;
    exp_ready = !m_flush_cycle && (m_q.size() < DEPTH);
    check({ctx, ".ready"}, 32'(pred_ready_o), 32'(exp_ready));
    model_clock(pv, pt, palt, rv, rt);
    @(posedge clk_i);
    #1;
    check_outputs(ctx);
  endtask

  task automatic idle(input string ctx);
    step(ctx, 0, 0, '0, 0, 0);
  endtask

  initial begin
    bit pv, pt, rv, rt;
    pred_valid_i = 0; pred_taken_i = 0; pred_alt_pc_i = '0;
    res_valid_i = 0; res_taken_i = 0;
    rst_i = 1'b1;
    model_reset();
    #3;
    check("reset.ready", 32'(pred_ready_o), 32'd1);
    check_outputs("reset");
    @(negedge clk_i);
    rst_i = 1'b0;

    // Correct stream: fill to DEPTH, then resolve all as taken
    step("fill0", 1, 1, 32'h100, 0, 0);
    step("fill1", 1, 1, 32'h104, 0, 0);
    step("fill2", 1, 1, 32'h108, 0, 0);
    step("fill3", 1, 1, 32'h10C, 0, 0);
    #1;
    check("full.ready", 32'(pred_ready_o), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step("res_ok", 0, 0, '0, 1, 1);
      check("res_ok.upd_valid_c", 32'(upd_valid_o), 32'd1);
    end
    check("stream.branch_cnt", 32'(branch_cnt_o), 32'd4);
    check("stream.mispred_cnt", 32'(mispred_cnt_o), 32'd0);

    // Mispredict with a push attempted during the flush cycle
    step("mp_push0", 1, 1, 32'h200, 0, 0);
    step("mp_push1", 1, 0, 32'h300, 0, 0);
    step("mp_res", 0, 0, '0, 1, 0);
    check("mp.flush_c", 32'(flush_o), 32'd1);
    check("mp.redirect_c", redirect_pc_o, 32'h200);
    check("mp.inflight_c", 32'(inflight_o), 32'd0);
    check("mp.ready_in_flush", 32'(pred_ready_o), 32'd0);
    step("mp_flushpush", 1, 1, 32'h999, 1, 1);
    check("mp.after_flush_inflight", 32'(inflight_o), 32'd0);
    check("mp.redirect_hold", redirect_pc_o, 32'h200);

    // Full queue with a simultaneous correct resolve and push
    for (int i = 0; i < 4; i++) step("full_fill", 1, 1, 32'h500 + 32'(4 * i), 0, 0);
    step("full_simul", 1, 0, 32'h400, 1, 1);
    check("simul.inflight_c", 32'(inflight_o), 32'd4);
    for (int i = 0; i < 3; i++) step("simul_drain", 0, 0, '0, 1, 1);
    step("simul_last", 0, 0, '0, 1, 0);
    check("simul.last_pred_c", 32'(upd_pred_o), 32'd0);
    check("simul.no_flush_c", 32'(flush_o), 32'd0);

    // Empty resolve sets sticky error
    step("empty_res", 0, 0, '0, 1, 1);
    check("empty.err_c", 32'(err_o), 32'd1);
    idle("empty_idle");
    check("empty.err_sticky", 32'(err_o), 32'd1);

    // Mid-cycle asynchronous reset with entries queued
    for (int i = 0; i < 3; i++) step("rst_fill", 1, 1, 32'h600 + 32'(i), 0, 0);
    @(negedge clk_i);
    pred_valid_i = 0; res_valid_i = 0;
    #2;
    rst_i = 1'b1;
    #1;
    model_reset();
    check("midrst.ready", 32'(pred_ready_o), 32'd1);
    check_outputs("midrst");
    @(negedge clk_i);
    rst_i = 1'b0;

    // Saturation: 17 mispredicts with a 4-bit counter
    for (int i = 0; i < 17; i++) begin
      step("sat_push", 1, 1, 32'h700 + 32'(i), 0, 0);
      step("sat_res", 0, 0, '0, 1, 0);
      idle("sat_flush");
    end
    check("sat.mispred_c", 32'(mispred_cnt_o), 32'hF);
    check("sat.branch_c", 32'(branch_cnt_o), 32'hF);

    // Random traffic against the model, starting from a fresh reset
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    model_reset();
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int i = 0; i < 400; i++) begin
      pv = ($urandom_range(0, 99) < 60);
      pt = $urandom_range(0, 1);
      rv = ($urandom_range(0, 99) < 45);
      if (m_q.size() > 0 && $urandom_range(0, 99) < 80) rt = m_q[0].taken;
      else rt = $urandom_range(0, 1);
      step("rand", pv, pt, $urandom, rv, rt);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
Sequencing controller wrapped around the 2-bit branch predictor in the pipelined CPU. Tracks in-flight predicted branches between fetch and resolution in an in-order queue. Compares each resolved outcome with its recorded prediction and issues the predictor update. On a mispredict it raises a one-cycle flush with the redirect PC, squashes younger in-flight entries and keeps saturating branch/mispredict statistics.

Parameters:
DEPTH, 4, max in-flight predicted branches; power of two, 2..16
PC_W, 32, PC width
CNT_W, 16, statistics counter width

Ports:
clk_i  input  1  clock; all state updates on rising edge
rst_i  input  1  asynchronous, active-high reset
pred_valid_i  input  1  fetch issues a predicted branch this cycle
pred_taken_i  input  1  prediction taken (predict_o of predictor)
pred_alt_pc_i  input  PC_W  PC to redirect to if this prediction is wrong
pred_ready_o  output  1  queue can accept a push this cycle
res_valid_i  input  1  oldest in-flight branch resolved this cycle
res_taken_i  input  1  actual branch outcome
flush_o  output  1  one-cycle mispredict flush pulse
redirect_pc_o  output  PC_W  redirect target, valid while flush_o=1
upd_valid_o  output  1  predictor update strobe (drives Branch_i)
upd_taken_o  output  1  actual outcome to predictor
upd_pred_o  output  1  recorded prediction to predictor
inflight_o  output  log2(DEPTH)+1  current queue occupancy
branch_cnt_o  output  CNT_W  resolved branches, saturating
mispred_cnt_o  output  CNT_W  mispredicts, saturating
err_o  output  1  sticky: resolve with empty queue

Behaviour:
- Reset (async, rst_i=1): queue empty, head/tail/count=0, state RUN, all outputs 0 except pred_ready_o=1; redirect_pc_o=0; counters 0; err_o=0. Reset mid-operation drops all entries immediately.
- Queue entry = {pred_taken, alt_pc}; circular buffer, head/tail wrap modulo DEPTH.
- FSM states: RUN, FLUSH.
- RUN: pred_ready_o = (count<DEPTH). A push is accepted when pred_valid_i & pred_ready_o. Push while full is dropped, with no state change.
- Resolve in RUN with count>0: pop head. Registered outputs on the next cycle: upd_valid_o=1, upd_taken_o=res_taken_i, upd_pred_o=entry.pred_taken; branch_cnt_o+1, saturating at all-ones.
- Correct resolve (res_taken_i == entry.pred_taken): no flush. A push in the same cycle is allowed and is accepted even if count==DEPTH (net count unchanged); pred_ready_o stays combinationally tied to count<DEPTH.
- Mispredict: next cycle flush_o=1, redirect_pc_o=entry.alt_pc, mispred_cnt_o+1 (saturating). All entries, including any push in the same cycle, are discarded; count=0; FSM -> FLUSH.
- FLUSH: lasts exactly one cycle (the cycle flush_o=1). pred_ready_o=0. pred_valid_i and res_valid_i are ignored. Next state RUN.
- Resolve with count==0 (in RUN): ignored except err_o <= 1 (sticky until reset). No update strobe.
- upd_valid_o and flush_o are single-cycle pulses; latency from res_valid_i is 1 cycle.
- redirect_pc_o holds its last value when flush_o=0.
- Back-to-back resolves, one per cycle, are supported in RUN.

Test Plan:
- Reset: assert rst_i mid-cycle with 3 entries queued -> immediately inflight_o=0, pred_ready_o=1, counters 0, flush_o=0.
- Correct stream: push 4 (taken=1, alt=0x100,0x104,0x108,0x10C) -> pred_ready_o=0 at count 4. Resolve 4 taken -> 4 upd_valid_o pulses with upd_taken_o=upd_pred_o=1, branch_cnt_o=4, mispred_cnt_o=0, no flush.
- Mispredict: push (1,0x200),(0,0x300); resolve res_taken_i=0 -> next cycle flush_o=1, redirect_pc_o=0x200, inflight_o=0, mispred_cnt_o=1. Push during the flush cycle is ignored.
- Full + simultaneous: count=4, push (0,0x400) with a correct resolve in the same cycle -> count stays 4, new entry is at the tail and resolves last.
- Empty resolve: res_valid_i with count 0 -> err_o=1 sticky, no upd_valid_o, counters unchanged.
- Saturation: with CNT_W=4, 17 mispredicts -> mispred_cnt_o and branch_cnt_o hold 0xF.
